// File: rtl/axi_pkg.sv
// Shared AXI codes and widths used by the read arbiter and its bench.
package axi_pkg;

  localparam int unsigned LEN_WIDTH   = 8;
  localparam int unsigned SIZE_WIDTH  = 3;
  localparam int unsigned BURST_WIDTH = 2;
  localparam int unsigned RESP_WIDTH  = 2;

  typedef enum logic [BURST_WIDTH-1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [RESP_WIDTH-1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping to 0.
module rr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned IDX_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]   grant_onehot,
  output logic [IDX_WIDTH-1:0] grant_idx
);

  logic found;

  // Two passes: indices from ptr upward first, then the wrapped-around low indices.
  always_comb begin
    found        = 1'b0;
    grant_idx    = '0;
    grant_onehot = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && req[k] && (IDX_WIDTH'(k) >= ptr)) begin
        found           = 1'b1;
        grant_idx       = IDX_WIDTH'(k);
        grant_onehot[k] = 1'b1;
      end
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && req[k] && (IDX_WIDTH'(k) < ptr)) begin
        found           = 1'b1;
        grant_idx       = IDX_WIDTH'(k);
        grant_onehot[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// N-to-1 AXI read arbiter: one burst outstanding, round-robin grant, no buffering.
module axi_read_arbiter
  import axi_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned RUSER_WIDTH = 32,
  parameter int unsigned ID_WIDTH    = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  // upstream AR, packed per master
  input  logic [NUM_MASTERS-1:0]            s_axi_arvalid,
  output logic [NUM_MASTERS-1:0]            s_axi_arready,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [NUM_MASTERS*ID_WIDTH-1:0]   s_axi_arid,
  input  logic [NUM_MASTERS*LEN_WIDTH-1:0]  s_axi_arlen,
  input  logic [NUM_MASTERS*SIZE_WIDTH-1:0] s_axi_arsize,
  input  logic [NUM_MASTERS*BURST_WIDTH-1:0] s_axi_arburst,
  // upstream R, payload broadcast
  output logic [NUM_MASTERS-1:0]            s_axi_rvalid,
  input  logic [NUM_MASTERS-1:0]            s_axi_rready,
  output logic [DATA_WIDTH-1:0]             s_axi_rdata,
  output logic [RUSER_WIDTH-1:0]            s_axi_ruser,
  output logic [ID_WIDTH-1:0]               s_axi_rid,
  output logic [RESP_WIDTH-1:0]             s_axi_rresp,
  output logic                              s_axi_rlast,
  // downstream AR
  output logic                              m_axi_arvalid,
  input  logic                              m_axi_arready,
  output logic [ADDR_WIDTH-1:0]             m_axi_araddr,
  output logic [ID_WIDTH-1:0]               m_axi_arid,
  output logic [LEN_WIDTH-1:0]              m_axi_arlen,
  output logic [SIZE_WIDTH-1:0]             m_axi_arsize,
  output logic [BURST_WIDTH-1:0]            m_axi_arburst,
  // downstream R
  input  logic                              m_axi_rvalid,
  output logic                              m_axi_rready,
  input  logic [DATA_WIDTH-1:0]             m_axi_rdata,
  input  logic [RUSER_WIDTH-1:0]            m_axi_ruser,
  input  logic [ID_WIDTH-1:0]               m_axi_rid,
  input  logic [RESP_WIDTH-1:0]             m_axi_rresp,
  input  logic                              m_axi_rlast
);

  localparam int unsigned IDX_WIDTH = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  arb_state_e             state;
  logic [IDX_WIDTH-1:0]   ptr;
  logic [IDX_WIDTH-1:0]   grant;
  logic [IDX_WIDTH-1:0]   pick_idx;
  logic [NUM_MASTERS-1:0] pick_onehot;
  logic                   sel_arvalid;
  logic                   sel_rready;

  function automatic logic [IDX_WIDTH-1:0] next_ptr(input logic [IDX_WIDTH-1:0] idx);
    if (idx == IDX_WIDTH'(NUM_MASTERS - 1)) return '0;
    return idx + IDX_WIDTH'(1);
  endfunction

  rr_arbiter #(
    .NUM_REQ   (NUM_MASTERS),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_rr_arbiter (
    .req          (s_axi_arvalid),
    .ptr          (ptr),
    .grant_onehot (pick_onehot),
    .grant_idx    (pick_idx)
  );

  // Arbitration FSM; grant and ptr only change when leaving IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      ptr   <= '0;
      grant <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|pick_onehot) begin
            grant <= pick_idx;
            ptr   <= next_ptr(pick_idx);
            state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (m_axi_arvalid && m_axi_arready) state <= ST_DATA;
        end
        ST_DATA: begin
          if (m_axi_rvalid && m_axi_rready && m_axi_rlast) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Select the granted master's AR fields and its rready.
  always_comb begin
    sel_arvalid   = 1'b0;
    sel_rready    = 1'b0;
    m_axi_araddr  = '0;
    m_axi_arid    = '0;
    m_axi_arlen   = '0;
    m_axi_arsize  = '0;
    m_axi_arburst = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      if (IDX_WIDTH'(k) == grant) begin
        sel_arvalid   = s_axi_arvalid[k];
        sel_rready    = s_axi_rready[k];
        m_axi_araddr  = s_axi_araddr[k*ADDR_WIDTH +: ADDR_WIDTH];
        m_axi_arid    = s_axi_arid[k*ID_WIDTH +: ID_WIDTH];
        m_axi_arlen   = s_axi_arlen[k*LEN_WIDTH +: LEN_WIDTH];
        m_axi_arsize  = s_axi_arsize[k*SIZE_WIDTH +: SIZE_WIDTH];
        m_axi_arburst = s_axi_arburst[k*BURST_WIDTH +: BURST_WIDTH];
      end
    end
  end

  // Handshake routing; stray downstream beats outside DATA are dropped.
  always_comb begin
    s_axi_arready = '0;
    s_axi_rvalid  = '0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    case (state)
      ST_ADDR: begin
        m_axi_arvalid        = sel_arvalid;
        s_axi_arready[grant] = m_axi_arready;
      end
      ST_DATA: begin
        s_axi_rvalid[grant] = m_axi_rvalid;
        m_axi_rready        = sel_rready;
      end
      default: ;
    endcase
  end

  // R payload is broadcast untouched; rvalid picks the receiver.
  assign s_axi_rdata = m_axi_rdata;
  assign s_axi_ruser = m_axi_ruser;
  assign s_axi_rid   = m_axi_rid;
  assign s_axi_rresp = m_axi_rresp;
  assign s_axi_rlast = m_axi_rlast;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Randomized bench for axi_read_arbiter with a transaction-level round-robin model.
module tb_axi_read_arbiter;
  import axi_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned UW = 32;
  localparam int unsigned IW = 1;

  logic clk = 1'b0;
  logic reset;

  logic [N-1:0]      s_axi_arvalid, s_axi_arready;
  logic [N*AW-1:0]   s_axi_araddr;
  logic [N*IW-1:0]   s_axi_arid;
  logic [N*8-1:0]    s_axi_arlen;
  logic [N*3-1:0]    s_axi_arsize;
  logic [N*2-1:0]    s_axi_arburst;
  logic [N-1:0]      s_axi_rvalid, s_axi_rready;
  logic [DW-1:0]     s_axi_rdata;
  logic [UW-1:0]     s_axi_ruser;
  logic [IW-1:0]     s_axi_rid;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rlast;
  logic              m_axi_arvalid, m_axi_arready;
  logic [AW-1:0]     m_axi_araddr;
  logic [IW-1:0]     m_axi_arid;
  logic [7:0]        m_axi_arlen;
  logic [2:0]        m_axi_arsize;
  logic [1:0]        m_axi_arburst;
  logic              m_axi_rvalid, m_axi_rready;
  logic [DW-1:0]     m_axi_rdata;
  logic [UW-1:0]     m_axi_ruser;
  logic [IW-1:0]     m_axi_rid;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rlast;

  axi_read_arbiter #(
    .NUM_MASTERS (N), .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .RUSER_WIDTH (UW), .ID_WIDTH (IW)
  ) dut (
    .clk (clk), .reset (reset),
    .s_axi_arvalid (s_axi_arvalid), .s_axi_arready (s_axi_arready),
    .s_axi_araddr (s_axi_araddr), .s_axi_arid (s_axi_arid), .s_axi_arlen (s_axi_arlen),
    .s_axi_arsize (s_axi_arsize), .s_axi_arburst (s_axi_arburst),
    .s_axi_rvalid (s_axi_rvalid), .s_axi_rready (s_axi_rready),
    .s_axi_rdata (s_axi_rdata), .s_axi_ruser (s_axi_ruser), .s_axi_rid (s_axi_rid),
    .s_axi_rresp (s_axi_rresp), .s_axi_rlast (s_axi_rlast),
    .m_axi_arvalid (m_axi_arvalid), .m_axi_arready (m_axi_arready),
    .m_axi_araddr (m_axi_araddr), .m_axi_arid (m_axi_arid), .m_axi_arlen (m_axi_arlen),
    .m_axi_arsize (m_axi_arsize), .m_axi_arburst (m_axi_arburst),
    .m_axi_rvalid (m_axi_rvalid), .m_axi_rready (m_axi_rready),
    .m_axi_rdata (m_axi_rdata), .m_axi_ruser (m_axi_ruser), .m_axi_rid (m_axi_rid),
    .m_axi_rresp (m_axi_rresp), .m_axi_rlast (m_axi_rlast)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state: pending requests per master and the round-robin start point.
  logic [N-1:0] pend;
  int           ptr_m;
  logic [AW-1:0] addr_q  [N];
  logic [7:0]    len_q   [N];
  logic [IW-1:0] id_q    [N];
  logic [2:0]    size_q  [N];
  logic [1:0]    burst_q [N];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick();
    for (int k = 0; k < int'(N); k++) begin
      if (pend[(ptr_m + k) % N]) return (ptr_m + k) % N;
    end
    return 0;
  endfunction

  task automatic post(input int i, input logic [AW-1:0] a, input logic [7:0] l);
    pend[i]    = 1'b1;
    addr_q[i]  = a;
    len_q[i]   = l;
    id_q[i]    = IW'($urandom);
    size_q[i]  = 3'($urandom_range(2));
    burst_q[i] = 2'($urandom_range(2));
  endtask

  task automatic apply_ar();
    for (int i = 0; i < int'(N); i++) begin
      s_axi_arvalid[i]          = pend[i];
      s_axi_araddr[i*AW +: AW]  = addr_q[i];
      s_axi_arlen[i*8 +: 8]     = len_q[i];
      s_axi_arid[i*IW +: IW]    = id_q[i];
      s_axi_arsize[i*3 +: 3]    = size_q[i];
      s_axi_arburst[i*2 +: 2]   = burst_q[i];
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pend  = '0;
    ptr_m = 0;
    apply_ar();
    m_axi_rvalid  = 1'b1;
    m_axi_rlast   = 1'b0;
    m_axi_arready = 1'b1;
    s_axi_rready  = '1;
    repeat (2) begin
      @(negedge clk); #1;
      chk("rst_outputs", {s_axi_arready, s_axi_rvalid, m_axi_arvalid, m_axi_rready}, 0);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_outputs", {s_axi_arready, s_axi_rvalid, m_axi_arvalid, m_axi_rready}, 0);
  endtask

  // One arbitration round: IDLE cycle, address phase, data phase (optionally cut by reset).
  task automatic run_txn(input bit glitch, input bit stall, input int resp_code,
                         input int abort_beat, output bit aborted);
    int w, cnt, beats, total, stall_left;
    bit done, have, exp_v;
    logic [N-1:0]  oh;
    logic [DW-1:0] cd;
    logic [UW-1:0] cu;
    logic [IW-1:0] ci;
    logic [1:0]    cr;
    aborted = 1'b0;
    w = rr_pick();
    oh = '0;
    oh[w] = 1'b1;
    cd = '0; cu = '0; ci = '0; cr = '0;

    @(negedge clk);
    apply_ar();
    m_axi_arready = 1'($urandom);
    m_axi_rvalid  = 1'($urandom);
    m_axi_rlast   = 1'b1;
    s_axi_rready  = N'($urandom);
    #1;
    chk("idle_m_arvalid", m_axi_arvalid, 0);
    chk("idle_s_arready", s_axi_arready, 0);
    chk("idle_s_rvalid", s_axi_rvalid, 0);
    chk("idle_m_rready", m_axi_rready, 0);
    ptr_m = (w + 1) % N;

    done = 1'b0;
    cnt  = 0;
    while (!done && cnt < 20) begin
      @(negedge clk);
      apply_ar();
      exp_v = !(glitch && cnt == 0);
      if (!exp_v) s_axi_arvalid[w] = 1'b0;
      m_axi_arready = (cnt >= 3 || !exp_v) ? 1'b1 : 1'($urandom);
      m_axi_rvalid  = 1'($urandom);
      m_axi_rdata   = $urandom;
      s_axi_rready  = N'($urandom);
      #1;
      chk("addr_m_arvalid", m_axi_arvalid, exp_v);
      chk("addr_araddr", m_axi_araddr, addr_q[w]);
      chk("addr_arlen", m_axi_arlen, len_q[w]);
      chk("addr_arid", m_axi_arid, id_q[w]);
      chk("addr_arsize", m_axi_arsize, size_q[w]);
      chk("addr_arburst", m_axi_arburst, burst_q[w]);
      chk("addr_s_arready", s_axi_arready, m_axi_arready ? oh : N'(0));
      chk("addr_rvalid_drop", s_axi_rvalid, 0);
      chk("addr_rready_drop", m_axi_rready, 0);
      if (exp_v && m_axi_arready) begin
        done = 1'b1;
        pend[w] = 1'b0;
      end
      cnt++;
    end
    if (!done) chk("addr_timeout", 0, 1);

    beats = 0;
    total = int'(len_q[w]) + 1;
    cnt = 0;
    have = 1'b0;
    stall_left = stall ? 5 : 0;
    while (done && beats < total && cnt < 300) begin
      @(negedge clk);
      if (abort_beat >= 0 && beats == abort_beat) begin
        aborted = 1'b1;
        break;
      end
      apply_ar();
      if (!have && $urandom_range(3) != 0) begin
        have = 1'b1;
        cd = $urandom;
        cu = $urandom;
        if (resp_code >= 0) begin
          ci = IW'(1);
          cr = 2'(resp_code);
        end else begin
          ci = IW'($urandom);
          cr = 2'($urandom);
        end
      end
      m_axi_rvalid  = have;
      m_axi_rdata   = cd;
      m_axi_ruser   = cu;
      m_axi_rid     = ci;
      m_axi_rresp   = cr;
      m_axi_rlast   = (beats == total - 1);
      m_axi_arready = 1'($urandom);
      s_axi_rready  = N'($urandom);
      if (stall_left > 0 && beats == 1 && have) begin
        s_axi_rready[w] = 1'b0;
        stall_left--;
      end
      #1;
      chk("data_s_rvalid", s_axi_rvalid, have ? oh : N'(0));
      chk("data_m_rready", m_axi_rready, s_axi_rready[w]);
      if (have) begin
        chk("data_rdata", s_axi_rdata, cd);
        chk("data_ruser", s_axi_ruser, cu);
        chk("data_rid", s_axi_rid, ci);
        chk("data_rresp", s_axi_rresp, cr);
        chk("data_rlast", s_axi_rlast, beats == total - 1);
      end
      chk("data_no_new_ar", {s_axi_arready, m_axi_arvalid}, 0);
      if (have && s_axi_rready[w]) begin
        beats++;
        have = 1'b0;
      end
      cnt++;
    end
    if (done && !aborted) chk("data_beats", beats, total);
  endtask

  initial begin
    bit ab;
    reset = 1'b1;
    pend = '0;
    ptr_m = 0;
    for (int i = 0; i < int'(N); i++) post(i, '0, '0);
    pend = '0;
    apply_ar();
    s_axi_rready = '0;
    m_axi_arready = 1'b0;
    m_axi_rvalid = 1'b0;
    m_axi_rdata = '0;
    m_axi_ruser = '0;
    m_axi_rid = '0;
    m_axi_rresp = '0;
    m_axi_rlast = 1'b0;
    do_reset();

    // single master 2, 4-beat burst at 0x40
    post(2, 32'h40, 8'd3);
    run_txn(1'b0, 1'b0, -1, -1, ab);

    // simultaneous 0,1,3 from a fresh pointer: order 0,1,3 then pointer wraps to 0
    do_reset();
    post(0, 32'h1000, 8'd1);
    post(1, 32'h2000, 8'd2);
    post(3, 32'h3000, 8'd0);
    repeat (3) run_txn(1'b0, 1'b0, -1, -1, ab);
    post(0, 32'h1100, 8'd0);
    post(3, 32'h3300, 8'd0);
    repeat (2) run_txn(1'b0, 1'b0, -1, -1, ab);

    // SLVERR with rid=1 forwarded unchanged
    post(1, 32'h80, 8'd2);
    run_txn(1'b0, 1'b0, int'(RESP_SLVERR), -1, ab);

    // 5-cycle back-pressure mid burst
    post(2, 32'hC0, 8'd5);
    run_txn(1'b0, 1'b1, -1, -1, ab);

    // granted master drops arvalid in the address phase
    post(0, 32'hE0, 8'd1);
    post(2, 32'hF0, 8'd0);
    run_txn(1'b1, 1'b0, -1, -1, ab);
    run_txn(1'b0, 1'b0, -1, -1, ab);

    // random traffic
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < int'(N); i++)
        if (!pend[i] && $urandom_range(1) == 1) post(i, $urandom, 8'($urandom_range(4)));
      if (pend == '0) post(int'($urandom_range(N - 1)), $urandom, 8'($urandom_range(4)));
      run_txn(1'($urandom_range(3) == 0), 1'b0, -1, -1, ab);
    end
    while (pend != '0) run_txn(1'b0, 1'b0, -1, -1, ab);

    // reset during beat 2 of an 8-beat burst, then 1 and 3 compete from pointer 0
    post(2, 32'h200, 8'd7);
    run_txn(1'b0, 1'b0, -1, 2, ab);
    do_reset();
    post(1, 32'h300, 8'd1);
    post(3, 32'h400, 8'd1);
    run_txn(1'b0, 1'b0, -1, -1, ab);
    run_txn(1'b0, 1'b0, -1, -1, ab);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_read_arbiter.md
AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 Param NUM_MASTERS, default 4: number of upstream AXI read masters (legal range 2..8).
REQ-002 Params ADDR_WIDTH 32, DATA_WIDTH 32, RUSER_WIDTH 32, ID_WIDTH 1: per-channel widths, identical on all ports.
REQ-003 clk  in  1  clock; reset  in  1  reset (synchronous, active-high).
REQ-004 s_axi_arvalid/s_axi_arready  in/out  NUM_MASTERS  per-master AR handshake; bit i = master i.
REQ-005 s_axi_araddr, s_axi_arid, s_axi_arlen, s_axi_arsize, s_axi_arburst  in  NUM_MASTERS*field width  per-master AR payload, packed; master i occupies slice [i*W +: W].
REQ-006 s_axi_rvalid  out  NUM_MASTERS; s_axi_rready  in  NUM_MASTERS  per-master R handshake.
REQ-007 s_axi_rdata, s_axi_ruser, s_axi_rid, s_axi_rresp, s_axi_rlast  out  unpacked per field (DATA_WIDTH, RUSER_WIDTH, ID_WIDTH, 2, 1)  R payload, broadcast to all masters.
REQ-008 m_axi_ar* (arvalid, arready, araddr, arid, arlen, arsize, arburst)  out/in  single-port widths  downstream AR to the shared read slave.
REQ-009 m_axi_r* (rvalid, rready, rdata, ruser, rid, rresp, rlast)  in/out  single-port widths  downstream R from the shared read slave.

Function
REQ-010 The block SHALL allow exactly one burst outstanding downstream at any time.
REQ-011 FSM states: IDLE, ADDR, DATA.
REQ-012 IDLE: all s_axi_arready=0, m_axi_arvalid=0; when any s_axi_arvalid is high, the round-robin winner SHALL be registered as grant and the FSM SHALL move to ADDR next cycle.
REQ-013 Round-robin: search starts at index ptr; on grant, ptr <= grant+1, wrapping NUM_MASTERS-1 -> 0.
REQ-014 ADDR: m_axi_ar* SHALL equal the granted master's AR fields, s_axi_arready[grant]=m_axi_arready, all other arready bits 0; on m_axi_arvalid & m_axi_arready -> DATA.
REQ-015 DATA: s_axi_rvalid[grant]=m_axi_rvalid, other rvalid bits 0; m_axi_rready=s_axi_rready[grant]; rready from non-granted masters SHALL be ignored.
REQ-016 DATA: on m_axi_rvalid & m_axi_rready & m_axi_rlast -> IDLE; non-last beats stay in DATA.
REQ-017 R payload, including rid, rresp and ruser, SHALL pass through combinationally without modification; SLVERR/DECERR SHALL be forwarded unchanged.
REQ-018 Latency: arvalid asserted in cycle N in IDLE -> m_axi_arvalid high in cycle N+1; rlast handshake in cycle M -> next grant no earlier than cycle M+2.
REQ-019 Simultaneous requests: exactly one grant; losers keep arvalid high and SHALL be served in round-robin order.
REQ-020 If the granted master deasserts arvalid in ADDR (protocol violation), m_axi_arvalid SHALL follow it low and the FSM SHALL stay in ADDR.
REQ-021 m_axi_rvalid high in IDLE or ADDR SHALL be dropped (m_axi_rready=0) and no s_axi_rvalid asserted.

Reset
REQ-022 On reset: state=IDLE, ptr=0, grant=0; all s_axi_arready, s_axi_rvalid, m_axi_arvalid, m_axi_rready SHALL be 0 in the cycle following reset.
REQ-023 Reset mid-burst SHALL abandon the burst; no beats of it SHALL be forwarded after reset.

Structure
REQ-024 Burst codes (FIXED/INCR/WRAP) and response codes (OKAY/EXOKAY/SLVERR/DECERR) SHALL come from the shared package axi_pkg.
REQ-025 Round-robin selection SHALL be the sub-module rr_arbiter (request vector, ptr in -> one-hot grant + index out, purely combinational).
REQ-026 State, ptr and grant registers SHALL live in axi_read_arbiter; no data buffering.

Verification
REQ-027 Single master 2 arvalid, araddr=0x40, arlen=3 -> m_axi_araddr=0x40 one cycle later; 4 beats reach master 2 only; rlast on the 4th beat; FSM returns to IDLE.
REQ-028 Masters 0,1,3 request in the same cycle with ptr=0 -> grant order 0,1,3; ptr=0 after the grant to master 3.
REQ-029 Downstream rready back-pressure: master holds rready=0 for 5 cycles mid-burst -> m_axi_rready=0 for those cycles, no beat lost or duplicated.
REQ-030 Downstream returns rresp=SLVERR, rid=1 -> master receives rresp=2'b10, rid=1 on the same cycle.
REQ-031 Reset asserted during beat 2 of an arlen=7 burst -> all valid/ready outputs 0 after reset; new request from master 1 served normally with ptr=0.
REQ-032 Non-granted master toggles rready during another master's burst -> no effect on m_axi_rready.
